// File: rtl/camera_pkg.sv
// Shared types and constants for the camera exposure/readout controller.
// Holds the state encoding, reset values and default readout timing used by RTL and bench.
package camera_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EXPOSE,
    RD_NRE,
    RD_ADC,
    RD_GAP
  } cam_state_t;

  localparam int NRE_CYC_DEF     = 2;
  localparam int ADC_CYC_DEF     = 1;
  localparam int WDOG_CYCLES_DEF = 64;

  localparam logic RST_START  = 1'b0;
  localparam logic RST_EXPOSE = 1'b0;
  localparam logic RST_ERASE  = 1'b1;
  localparam logic RST_NRE    = 1'b1;
  localparam logic RST_ADC    = 1'b0;
  localparam logic RST_BUSY   = 1'b0;
  localparam logic RST_ERR    = 1'b0;

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/cam_readout_seq.sv
// One-row readout timing: NRE low for NRE_CYC cycles, then NRE low with ADC high for ADC_CYC
// cycles, then a one-cycle gap. A go pulse (re)starts a row; done is high during the gap cycle.
module cam_readout_seq
  import camera_pkg::*;
#(
  parameter int NRE_CYC = NRE_CYC_DEF,
  parameter int ADC_CYC = ADC_CYC_DEF,
  parameter int CNT_W   = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic go,
  output logic done,
  output logic nre_n,
  output logic adc
);

  cam_state_t       phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             nre_n_q, nre_n_d;
  logic             adc_q, adc_d;

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    nre_n_d = nre_n_q;
    adc_d   = adc_q;
    if (go) begin
      phase_d = RD_NRE;
      cnt_d   = CNT_W'(NRE_CYC - 1);
      nre_n_d = 1'b0;
      adc_d   = 1'b0;
    end else begin
      case (phase_q)
        RD_NRE: begin
          if (cnt_q == '0) begin
            phase_d = RD_ADC;
            cnt_d   = CNT_W'(ADC_CYC - 1);
            adc_d   = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        RD_ADC: begin
          if (cnt_q == '0) begin
            phase_d = RD_GAP;
            nre_n_d = 1'b1;
            adc_d   = 1'b0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: phase_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= IDLE;
      cnt_q   <= '0;
      nre_n_q <= RST_NRE;
      adc_q   <= RST_ADC;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      nre_n_q <= nre_n_d;
      adc_q   <= adc_d;
    end
  end

  assign done  = (phase_q == RD_GAP);
  assign nre_n = nre_n_q;
  assign adc   = adc_q;

endmodule

// File: rtl/camera_ctrl_fsm.sv
// Exposure/readout controller for the 2x2 pixel camera: erase, expose until Ovf5, read both rows.
// Optional exposure watchdog enabled by defining CAM_WATCHDOG_EN.
module camera_ctrl_fsm
  import camera_pkg::*;
#(
  parameter int NRE_CYC     = NRE_CYC_DEF,
  parameter int ADC_CYC     = ADC_CYC_DEF,
  parameter int WDOG_CYCLES = WDOG_CYCLES_DEF
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Init,
  input  logic Ovf5,
  output logic Start,
  output logic Expose,
  output logic Erase,
  output logic NRE_1,
  output logic NRE_2,
  output logic ADC,
  output logic Busy,
  output logic Err
);

  localparam int CNT_W = cnt_width(NRE_CYC, ADC_CYC, WDOG_CYCLES);

  // Row timing lives in cam_readout_seq; this FSM sits in RD_NRE for the whole two-row readout.
  cam_state_t state_q, state_d;
  logic       r_q, r_d;
  logic       start_q, start_d;
  logic       expose_q, expose_d;
  logic       erase_q, erase_d;
  logic       busy_q, busy_d;
  logic       seq_go, seq_done, seq_nre_n, seq_adc;
`ifdef CAM_WATCHDOG_EN
  logic             err_q, err_d;
  logic [CNT_W-1:0] wdog_q, wdog_d;
`endif

  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    start_d  = 1'b0;
    expose_d = expose_q;
    erase_d  = erase_q;
    busy_d   = busy_q;
    seq_go   = 1'b0;
`ifdef CAM_WATCHDOG_EN
    err_d    = err_q;
    wdog_d   = wdog_q;
`endif
    case (state_q)
      IDLE: begin
        if (Init) begin
          state_d  = EXPOSE;
          start_d  = 1'b1;
          expose_d = 1'b1;
          erase_d  = 1'b0;
          busy_d   = 1'b1;
`ifdef CAM_WATCHDOG_EN
          err_d    = 1'b0;
          wdog_d   = CNT_W'(WDOG_CYCLES - 1);
`endif
        end
      end
      EXPOSE: begin
        // Ovf5 is checked first so a pulse on the watchdog's last cycle still completes normally.
        if (Ovf5) begin
          state_d  = RD_NRE;
          r_d      = 1'b0;
          expose_d = 1'b0;
          seq_go   = 1'b1;
        end
`ifdef CAM_WATCHDOG_EN
        else if (wdog_q == '0) begin
          state_d  = IDLE;
          expose_d = 1'b0;
          erase_d  = 1'b1;
          busy_d   = 1'b0;
          err_d    = 1'b1;
        end else begin
          wdog_d = wdog_q - 1'b1;
        end
`endif
      end
      RD_NRE: begin
        if (seq_done) begin
          if (r_q) begin
            state_d = IDLE;
            r_d     = 1'b0;
            erase_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            r_d    = 1'b1;
            seq_go = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      r_q      <= 1'b0;
      start_q  <= RST_START;
      expose_q <= RST_EXPOSE;
      erase_q  <= RST_ERASE;
      busy_q   <= RST_BUSY;
`ifdef CAM_WATCHDOG_EN
      err_q    <= RST_ERR;
      wdog_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      start_q  <= start_d;
      expose_q <= expose_d;
      erase_q  <= erase_d;
      busy_q   <= busy_d;
`ifdef CAM_WATCHDOG_EN
      err_q    <= err_d;
      wdog_q   <= wdog_d;
`endif
    end
  end

  cam_readout_seq #(
    .NRE_CYC(NRE_CYC),
    .ADC_CYC(ADC_CYC),
    .CNT_W  (CNT_W)
  ) u_seq (
    .clk  (Clk),
    .rst  (Reset),
    .go   (seq_go),
    .done (seq_done),
    .nre_n(seq_nre_n),
    .adc  (seq_adc)
  );

  assign Start  = start_q;
  assign Expose = expose_q;
  assign Erase  = erase_q;
  assign NRE_1  = r_q ? 1'b1 : seq_nre_n;
  assign NRE_2  = r_q ? seq_nre_n : 1'b1;
  assign ADC    = seq_adc;
  assign Busy   = busy_q;
`ifdef CAM_WATCHDOG_EN
  assign Err    = err_q;
`else
  assign Err    = 1'b0;
`endif

endmodule

// File: tb/tb_camera_ctrl_fsm.sv
// Bench for camera_ctrl_fsm: per-cycle vector table through a scoreboard queue, plus
// hand-written reset-abort and (with CAM_WATCHDOG_EN) watchdog sequences.
module tb_camera_ctrl_fsm;
  import camera_pkg::*;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  logic Init = 1'b0;
  logic Ovf5 = 1'b0;
  logic Start, Expose, Erase, NRE_1, NRE_2, ADC, Busy, Err;

  int checks = 0;
  int errors = 0;

  camera_ctrl_fsm #(
    .NRE_CYC    (NRE_CYC_DEF),
    .ADC_CYC    (ADC_CYC_DEF),
    .WDOG_CYCLES(WDOG_CYCLES_DEF)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Init  (Init),
    .Ovf5  (Ovf5),
    .Start (Start),
    .Expose(Expose),
    .Erase (Erase),
    .NRE_1 (NRE_1),
    .NRE_2 (NRE_2),
    .ADC   (ADC),
    .Busy  (Busy),
    .Err   (Err)
  );

  always #5 Clk = ~Clk;

  // Output vector order: {Start, Expose, Erase, NRE_1, NRE_2, ADC, Busy, Err}
  logic [7:0] outs;
  assign outs = {Start, Expose, Erase, NRE_1, NRE_2, ADC, Busy, Err};

  localparam logic [7:0] O_IDLE = 8'b0_0_1_1_1_0_0_0;
  localparam logic [7:0] O_EXP1 = 8'b1_1_0_1_1_0_1_0;
  localparam logic [7:0] O_EXP  = 8'b0_1_0_1_1_0_1_0;
  localparam logic [7:0] O_R1N  = 8'b0_0_0_0_1_0_1_0;
  localparam logic [7:0] O_R1A  = 8'b0_0_0_0_1_1_1_0;
  localparam logic [7:0] O_GAP  = 8'b0_0_0_1_1_0_1_0;
  localparam logic [7:0] O_R2N  = 8'b0_0_0_1_0_0_1_0;
  localparam logic [7:0] O_R2A  = 8'b0_0_0_1_0_1_1_0;

  typedef struct {
    logic       init;
    logic       ovf5;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    int         idx;
    logic [7:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbq[$];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (Start,Expose,Erase,NRE_1,NRE_2,ADC,Busy,Err)",
               name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic add(input logic i, input logic o, input logic [7:0] e);
    vec_t v;
    v.init = i;
    v.ovf5 = o;
    v.exp  = e;
    vecs.push_back(v);
  endtask

  task automatic add_tail_from_r1n_second();
    add(0, 0, O_R1N); add(0, 0, O_R1A); add(0, 0, O_GAP);
    add(0, 0, O_R2N); add(0, 0, O_R2N); add(0, 0, O_R2A); add(0, 0, O_GAP);
    add(0, 0, O_IDLE);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    sb_t s;
    // Normal picture, 5 exposure cycles; Init and Ovf5 pulses during readout are ignored.
    add(1, 0, O_EXP1);
    add(0, 0, O_EXP); add(0, 0, O_EXP); add(0, 0, O_EXP); add(0, 0, O_EXP);
    add(0, 1, O_R1N); add(0, 0, O_R1N); add(1, 0, O_R1A); add(0, 1, O_GAP);
    add(0, 0, O_R2N); add(0, 0, O_R2N); add(0, 1, O_R2A); add(0, 0, O_GAP);
    add(0, 0, O_IDLE);
    // Ovf5 in IDLE does nothing.
    add(0, 1, O_IDLE); add(0, 1, O_IDLE);
    // Ovf5 in the first exposure cycle.
    add(1, 0, O_EXP1); add(0, 1, O_R1N);
    add_tail_from_r1n_second();
    // Init and Ovf5 together in IDLE: Ovf5 dropped.
    add(1, 1, O_EXP1); add(0, 0, O_EXP); add(0, 1, O_R1N);
    add_tail_from_r1n_second();
    // Init held high: back-to-back pictures with a single IDLE cycle between.
    add(1, 0, O_EXP1); add(1, 1, O_R1N); add(1, 0, O_R1N); add(1, 0, O_R1A);
    add(1, 0, O_GAP); add(1, 0, O_R2N); add(1, 0, O_R2N); add(1, 0, O_R2A);
    add(1, 0, O_GAP); add(1, 0, O_IDLE); add(1, 0, O_EXP1); add(0, 0, O_EXP);
    add(0, 1, O_R1N);
    add_tail_from_r1n_second();

    #1 Reset = 1'b1;
    #2 check8("reset_state", outs, O_IDLE);
    @(negedge Clk);
    Reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      Init = vecs[i].init;
      Ovf5 = vecs[i].ovf5;
      s.idx = i;
      s.exp = vecs[i].exp;
      sbq.push_back(s);
      @(posedge Clk);
      @(negedge Clk);
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: got 0 entries expected 1");
      end else begin
        s = sbq.pop_front();
        check8($sformatf("vec%0d", s.idx), outs, s.exp);
      end
    end
    Init = 1'b0;
    Ovf5 = 1'b0;

    // Asynchronous reset in the middle of row-1 ADC strobe.
    Init = 1'b1;
    @(negedge Clk);
    Init = 1'b0;
    Ovf5 = 1'b1;
    @(negedge Clk);
    Ovf5 = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    check8("pre_reset_rd_adc", outs, O_R1A);
    #2 Reset = 1'b1;
    #1 check8("async_reset_abort", outs, O_IDLE);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check8("idle_after_abort", outs, O_IDLE);

`ifdef CAM_WATCHDOG_EN
    begin
      int n;
      logic bad;
      n = 0;
      bad = 1'b0;
      Init = 1'b1;
      @(negedge Clk);
      Init = 1'b0;
      while (Busy && n < 200) begin
        if (!NRE_1 || !NRE_2 || ADC) bad = 1'b1;
        if (Expose) n++;
        @(negedge Clk);
      end
      checks++;
      if (n != WDOG_CYCLES_DEF) begin
        errors++;
        $display("FAIL wdog_expose_cycles: got %0d expected %0d", n, WDOG_CYCLES_DEF);
      end
      check1("wdog_no_readout", bad, 1'b0);
      check8("wdog_timeout_state", outs, O_IDLE | 8'b0000_0001);
      @(negedge Clk);
      check1("wdog_err_sticky", Err, 1'b1);
      Init = 1'b1;
      @(negedge Clk);
      Init = 1'b0;
      check8("wdog_err_cleared", outs, O_EXP1);
      Ovf5 = 1'b1;
      @(negedge Clk);
      Ovf5 = 1'b0;
      repeat (8) @(negedge Clk);
      check8("wdog_normal_after", outs, O_IDLE);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
